reset_sequencer: RTL and testbench

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/npu_rst_pkg.sv | 20 ++
 rtl/rst_sync_2ff.sv | 24 ++
 rtl/reset_sequencer.sv | 174 +++++++++++++++++
 tb/tb_reset_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/npu_rst_pkg.sv
// Shared types for the reset sequencer: FSM states and reset-cause encoding.
package npu_rst_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'b00,
    RELEASE = 2'b01,
    RUN     = 2'b10
  } rst_state_e;

  typedef enum logic [1:0] {
    POR = 2'b00,
    SW  = 2'b01,
    WDT = 2'b10
  } rst_cause_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rst_sync_2ff.sv
// Two-flop reset synchronizer: asserts asynchronously, releases on the
// second rising clk edge after async_rst_n deasserts.
module rst_sync_2ff (
  input  logic clk,
  input  logic async_rst_n,
  output logic sync_rst_n
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= 1'b1;
      sync_q <= meta_q;
    end
  end

  assign sync_rst_n = sync_q;

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release: hold all domains for HOLD_CYCLES, then release them
// one by one STAGE_GAP cycles apart; SW/WDT requests restart the sequence.
module reset_sequencer
  import npu_rst_pkg::*;
#(
  parameter int NUM_STAGES  = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 4
) (
  input  logic                  clk,
  input  logic                  async_rst_n,
  input  logic                  sw_rst_req,
  input  logic                  wdt_rst_req,
  output logic                  sw_rst_ack,
  output logic [NUM_STAGES-1:0] stage_rst_n,
  output logic                  rst_busy,
  output logic                  rst_done,
  output logic [1:0]            rst_cause
);

  localparam int CW = $clog2(max_int(HOLD_CYCLES, STAGE_GAP) + 1);
  localparam int IW = $clog2(NUM_STAGES + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);
  localparam logic [IW-1:0] IDX_DONE  = IW'(NUM_STAGES);

  logic sync_rst_n;

  rst_sync_2ff u_sync (
    .clk         (clk),
    .async_rst_n (async_rst_n),
    .sync_rst_n  (sync_rst_n)
  );

  rst_state_e            state_q, state_d;
  logic [CW-1:0]         hold_cnt_q, hold_cnt_d;
  logic [CW-1:0]         gap_cnt_q, gap_cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [NUM_STAGES-1:0] stage_q, stage_d;
  logic                  rst_busy_q, rst_busy_d;
  logic                  rst_done_q, rst_done_d;
  logic                  sw_rst_ack_q, sw_rst_ack_d;
  rst_cause_e            rst_cause_q, rst_cause_d;
  logic                  pend_q, pend_d;
  rst_cause_e            pend_cause_q, pend_cause_d;

  logic [NUM_STAGES-1:0] rel_mask;
  logic                  sw_ok;
  logic                  req_any;
  logic                  pend_now;
  rst_cause_e            pend_cause_now;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_STAGES; gi++) begin : g_rel
      assign rel_mask[gi] = (idx_q == IW'(gi));
    end
  endgenerate

  // A requester that drops sw_rst_req after seeing the ack still has it high
  // on the ack cycle's edge; ignore SW on that edge so it is not re-accepted.
  assign sw_ok   = sw_rst_req && !sw_rst_ack_q;
  assign req_any = wdt_rst_req || sw_ok;

  assign pend_now       = pend_q || req_any;
  assign pend_cause_now = (wdt_rst_req || (pend_q && pend_cause_q == WDT)) ? WDT : SW;

  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    idx_d        = idx_q;
    stage_d      = stage_q;
    rst_done_d   = rst_done_q;
    sw_rst_ack_d = 1'b0;
    rst_cause_d  = rst_cause_q;
    pend_d       = pend_q;
    pend_cause_d = pend_cause_q;

    case (state_q)
      HOLD: begin
        pend_d       = pend_now;
        pend_cause_d = pend_cause_now;
        if (hold_cnt_q == HOLD_LAST) begin
          state_d    = RELEASE;
          hold_cnt_d = '0;
          gap_cnt_d  = '0;
          idx_d      = IW'(1);
          stage_d[0] = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      RELEASE: begin
        pend_d       = pend_now;
        pend_cause_d = pend_cause_now;
        if (idx_q == IDX_DONE) begin
          if (pend_now) begin
            state_d      = HOLD;
            stage_d      = '0;
            hold_cnt_d   = '0;
            rst_done_d   = 1'b0;
            rst_cause_d  = pend_cause_now;
            sw_rst_ack_d = (pend_cause_now == SW);
            pend_d       = 1'b0;
            pend_cause_d = POR;
          end else begin
            state_d    = RUN;
            rst_done_d = 1'b1;
          end
        end else if (gap_cnt_q == GAP_LAST) begin
          stage_d   = stage_q | rel_mask;
          idx_d     = idx_q + 1'b1;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (req_any) begin
          state_d      = HOLD;
          stage_d      = '0;
          hold_cnt_d   = '0;
          gap_cnt_d    = '0;
          idx_d        = '0;
          rst_done_d   = 1'b0;
          rst_cause_d  = wdt_rst_req ? WDT : SW;
          sw_rst_ack_d = !wdt_rst_req;
        end
      end
      default: begin
        state_d = HOLD;
        stage_d = '0;
      end
    endcase

    rst_busy_d = ~(&stage_d);
  end

  always_ff @(posedge clk or negedge sync_rst_n) begin
    if (!sync_rst_n) begin
      state_q      <= HOLD;
      hold_cnt_q   <= '0;
      gap_cnt_q    <= '0;
      idx_q        <= '0;
      stage_q      <= '0;
      rst_busy_q   <= 1'b1;
      rst_done_q   <= 1'b0;
      sw_rst_ack_q <= 1'b0;
      rst_cause_q  <= POR;
      pend_q       <= 1'b0;
      pend_cause_q <= POR;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      idx_q        <= idx_d;
      stage_q      <= stage_d;
      rst_busy_q   <= rst_busy_d;
      rst_done_q   <= rst_done_d;
      sw_rst_ack_q <= sw_rst_ack_d;
      rst_cause_q  <= rst_cause_d;
      pend_q       <= pend_d;
      pend_cause_q <= pend_cause_d;
    end
  end

  assign stage_rst_n = stage_q;
  assign rst_busy    = rst_busy_q;
  assign rst_done    = rst_done_q;
  assign sw_rst_ack  = sw_rst_ack_q;
  assign rst_cause   = rst_cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default instance plus a 1/1/1 instance
// sharing clk and async_rst_n.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       async_rst_n = 1'b1;
  logic       sw_rst_req = 1'b0;
  logic       wdt_rst_req = 1'b0;
  logic       sw_rst_ack;
  logic [2:0] stage_rst_n;
  logic       rst_busy;
  logic       rst_done;
  logic [1:0] rst_cause;

  logic       s_sw_req = 1'b0;
  logic       s_wdt_req = 1'b0;
  logic       s_ack;
  logic [0:0] s_stage;
  logic       s_busy;
  logic       s_done;
  logic [1:0] s_cause;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  reset_sequencer dut (
    .clk         (clk),
    .async_rst_n (async_rst_n),
    .sw_rst_req  (sw_rst_req),
    .wdt_rst_req (wdt_rst_req),
    .sw_rst_ack  (sw_rst_ack),
    .stage_rst_n (stage_rst_n),
    .rst_busy    (rst_busy),
    .rst_done    (rst_done),
    .rst_cause   (rst_cause)
  );

  reset_sequencer #(.NUM_STAGES(1), .HOLD_CYCLES(1), .STAGE_GAP(1)) dut_small (
    .clk         (clk),
    .async_rst_n (async_rst_n),
    .sw_rst_req  (s_sw_req),
    .wdt_rst_req (s_wdt_req),
    .sw_rst_ack  (s_ack),
    .stage_rst_n (s_stage),
    .rst_busy    (s_busy),
    .rst_done    (s_done),
    .rst_cause   (s_cause)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Default timing: stage0/1/2 release 16/20/24 cycles after the start edge.
  function automatic logic [2:0] exp_stage(input int k);
    if (k >= 24) return 3'b111;
    if (k >= 20) return 3'b011;
    if (k >= 16) return 3'b001;
    return 3'b000;
  endfunction

  task automatic test_reset;
    async_rst_n = 1'b0;
    sw_rst_req  = 1'b0;
    wdt_rst_req = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (stage_rst_n !== 3'b000) begin n_err++; $display("FAIL reset_stage got %b exp 000", stage_rst_n); end
    n_cmp++;
    if (rst_busy !== 1'b1) begin n_err++; $display("FAIL reset_busy got %b exp 1", rst_busy); end
    n_cmp++;
    if (rst_done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b exp 0", rst_done); end
    n_cmp++;
    if (sw_rst_ack !== 1'b0) begin n_err++; $display("FAIL reset_ack got %b exp 0", sw_rst_ack); end
    n_cmp++;
    if (rst_cause !== 2'b00) begin n_err++; $display("FAIL reset_cause got %b exp 00", rst_cause); end
    n_cmp++;
    if (s_stage !== 1'b0 || s_done !== 1'b0) begin
      n_err++; $display("FAIL reset_small got stage=%b done=%b exp 0/0", s_stage, s_done);
    end
    $display("reset: stage=%b busy=%b done=%b cause=%b", stage_rst_n, rst_busy, rst_done, rst_cause);
  endtask

  // POR: deassert, edge 1 then edge T, then check T+1..T+30.
  task automatic test_por;
    async_rst_n = 1'b0;
    tick();
    tick();
    async_rst_n = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (stage_rst_n !== 3'b000 || rst_busy !== 1'b1) begin
      n_err++; $display("FAIL por_T stage=%b busy=%b exp 000/1", stage_rst_n, rst_busy);
    end
    for (int k = 1; k <= 30; k++) begin
      tick();
      n_cmp++;
      if (stage_rst_n !== exp_stage(k)) begin
        n_err++; $display("FAIL por_stage k=%0d got %b exp %b", k, stage_rst_n, exp_stage(k));
      end
      n_cmp++;
      if (rst_done !== (k >= 25) || rst_busy !== (k < 24)) begin
        n_err++; $display("FAIL por_flags k=%0d done=%b busy=%b exp %b/%b", k, rst_done, rst_busy, k >= 25, k < 24);
      end
      n_cmp++;
      if (rst_cause !== 2'b00 || sw_rst_ack !== 1'b0) begin
        n_err++; $display("FAIL por_cause k=%0d cause=%b ack=%b exp 00/0", k, rst_cause, sw_rst_ack);
      end
      n_cmp++;
      if (s_stage !== (k >= 1) || s_done !== (k >= 2) || s_busy !== 1'b0) begin
        n_err++; $display("FAIL small_por k=%0d stage=%b done=%b busy=%b exp %b/%b/0", k, s_stage, s_done, s_busy, k >= 1, k >= 2);
      end
    end
    $display("por: stage=%b done=%b cause=%b small stage=%b done=%b", stage_rst_n, rst_done, rst_cause, s_stage, s_done);
  endtask

  // Accept a request in RUN, then verify the full re-sequence.
  task automatic test_request(input logic sw, input logic wdt, input logic hold_sw_extra);
    logic [1:0] exp_cause;
    logic       exp_ack;
    exp_cause = wdt ? 2'b10 : 2'b01;
    exp_ack   = sw && !wdt;
    sw_rst_req  = sw;
    wdt_rst_req = wdt;
    tick();
    if (!hold_sw_extra) sw_rst_req = 1'b0;
    wdt_rst_req = 1'b0;
    n_cmp++;
    if (stage_rst_n !== 3'b000 || rst_done !== 1'b0 || rst_busy !== 1'b1) begin
      n_err++; $display("FAIL req_accept stage=%b done=%b busy=%b exp 000/0/1", stage_rst_n, rst_done, rst_busy);
    end
    n_cmp++;
    if (sw_rst_ack !== exp_ack || rst_cause !== exp_cause) begin
      n_err++; $display("FAIL req_ack_cause ack=%b cause=%b exp %b/%b", sw_rst_ack, rst_cause, exp_ack, exp_cause);
    end
    for (int k = 1; k <= 26; k++) begin
      tick();
      sw_rst_req = 1'b0;
      n_cmp++;
      if (stage_rst_n !== exp_stage(k) || rst_done !== (k >= 25)) begin
        n_err++; $display("FAIL req_seq k=%0d stage=%b done=%b exp %b/%b", k, stage_rst_n, rst_done, exp_stage(k), k >= 25);
      end
      n_cmp++;
      if (sw_rst_ack !== 1'b0 || rst_cause !== exp_cause) begin
        n_err++; $display("FAIL req_hold k=%0d ack=%b cause=%b exp 0/%b", k, sw_rst_ack, rst_cause, exp_cause);
      end
    end
    $display("request sw=%b wdt=%b extra=%b: stage=%b done=%b cause=%b", sw, wdt, hold_sw_extra, stage_rst_n, rst_done, rst_cause);
  endtask

  // WDT restart, SW pulse while stage1 still low -> pending re-entry to HOLD.
  task automatic test_pending;
    logic [2:0] es;
    logic       ed;
    logic       ea;
    logic [1:0] ec;
    wdt_rst_req = 1'b1;
    tick();
    wdt_rst_req = 1'b0;
    for (int k = 1; k <= 51; k++) begin
      if (k == 17) sw_rst_req = 1'b1;
      tick();
      sw_rst_req = 1'b0;
      if (k < 25) begin
        es = exp_stage(k); ed = 1'b0; ea = 1'b0; ec = 2'b10;
      end else if (k == 25) begin
        es = 3'b000; ed = 1'b0; ea = 1'b1; ec = 2'b01;
      end else begin
        es = exp_stage(k - 25); ed = (k - 25 >= 25); ea = 1'b0; ec = 2'b01;
      end
      n_cmp++;
      if (stage_rst_n !== es || rst_done !== ed) begin
        n_err++; $display("FAIL pend_seq k=%0d stage=%b done=%b exp %b/%b", k, stage_rst_n, rst_done, es, ed);
      end
      n_cmp++;
      if (sw_rst_ack !== ea || rst_cause !== ec) begin
        n_err++; $display("FAIL pend_ack k=%0d ack=%b cause=%b exp %b/%b", k, sw_rst_ack, rst_cause, ea, ec);
      end
    end
    $display("pending: stage=%b done=%b cause=%b", stage_rst_n, rst_done, rst_cause);
  endtask

  // Async reset mid-RELEASE must clear outputs before any clk edge.
  task automatic test_async_mid;
    wdt_rst_req = 1'b1;
    tick();
    wdt_rst_req = 1'b0;
    for (int k = 1; k <= 17; k++) tick();
    n_cmp++;
    if (stage_rst_n !== 3'b001) begin
      n_err++; $display("FAIL async_pre stage=%b exp 001", stage_rst_n);
    end
    #2;
    async_rst_n = 1'b0;
    #1;
    n_cmp++;
    if (stage_rst_n !== 3'b000 || rst_busy !== 1'b1 || rst_done !== 1'b0) begin
      n_err++; $display("FAIL async_clear stage=%b busy=%b done=%b exp 000/1/0", stage_rst_n, rst_busy, rst_done);
    end
    n_cmp++;
    if (rst_cause !== 2'b00 || sw_rst_ack !== 1'b0 || s_stage !== 1'b0) begin
      n_err++; $display("FAIL async_cause cause=%b ack=%b small=%b exp 00/0/0", rst_cause, sw_rst_ack, s_stage);
    end
    $display("async mid-release: stage=%b busy=%b cause=%b", stage_rst_n, rst_busy, rst_cause);
    test_por();
  endtask

  initial begin
    #2;
    test_reset();
    test_por();
    test_request(1'b1, 1'b0, 1'b0);
    test_request(1'b1, 1'b1, 1'b0);
    test_request(1'b1, 1'b0, 1'b1);
    test_pending();
    test_async_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
